// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider: 50% duty divided clock of period 2*(DIV+1)
// plus a one-cycle TICK enable aligned to each rising edge of the divided clock.
module clkdiv_prog #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    DEF_DIV = W'(3)
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         EN,
    input  logic [W-1:0] DIV,
    output logic         CLK_OUT,
    output logic         TICK,
    output logic         ACTIVE
);

    logic [W-1:0] cnt;
    logic [W-1:0] d_act;
    logic         run;
    logic         clk_q;
    logic         tick_q;

    // The falling toggle of the divided clock is the period boundary: only there
    // are a new divisor and a stop request taken, so every pulse is full width.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cnt    <= '0;
            d_act  <= DEF_DIV;
            run    <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (!run) begin
                if (EN) begin
                    run   <= 1'b1;
                    cnt   <= '0;
                    d_act <= DIV;
                end
            end else if (cnt != d_act) begin
                cnt <= cnt + W'(1);
            end else begin
                cnt   <= '0;
                clk_q <= ~clk_q;
                if (!clk_q) begin
                    tick_q <= 1'b1;
                end else begin
                    d_act <= DIV;
                    if (!EN) begin
                        run <= 1'b0;
                    end
                end
            end
        end
    end

    assign CLK_OUT = clk_q;
    assign TICK    = tick_q;
    assign ACTIVE  = run;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: directed scenarios plus random DIV/EN traffic,
// all compared against a period-position reference model.
module tb_clkdiv_prog;

    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic       EN  = 1'b0;
    logic [7:0] DIV = 8'd0;
    logic       CLK_OUT;
    logic       TICK;
    logic       ACTIVE;

    int checks = 0;
    int errors = 0;

    clkdiv_prog #(.W(8), .DEF_DIV(8'd3)) dut (
        .CLK     (CLK),
        .RES     (RES),
        .EN      (EN),
        .DIV     (DIV),
        .CLK_OUT (CLK_OUT),
        .TICK    (TICK),
        .ACTIVE  (ACTIVE)
    );

    always #5 CLK = ~CLK;

    // Reference: age = edges since the period started (start edge or falling edge).
    // Output is high for ages D+1 .. 2D+1; age 2(D+1) is the boundary.
    bit m_run  = 1'b0;
    bit m_clk  = 1'b0;
    bit m_tick = 1'b0;
    int m_age  = 0;
    int m_d    = 3;

    always @(posedge CLK or negedge RES) begin
        if (!RES) begin
            m_run  <= 1'b0;
            m_clk  <= 1'b0;
            m_tick <= 1'b0;
            m_age  <= 0;
            m_d    <= 3;
        end else if (!m_run) begin
            m_clk  <= 1'b0;
            m_tick <= 1'b0;
            if (EN) begin
                m_run <= 1'b1;
                m_age <= 0;
                m_d   <= int'(DIV);
            end
        end else if (m_age + 1 == 2 * (m_d + 1)) begin
            m_age  <= 0;
            m_clk  <= 1'b0;
            m_tick <= 1'b0;
            m_d    <= int'(DIV);
            if (!EN) m_run <= 1'b0;
        end else begin
            m_age  <= m_age + 1;
            m_clk  <= (m_age + 1 >= m_d + 1);
            m_tick <= (m_age + 1 == m_d + 1);
        end
    end

    // Bounded waits (no checking here): return at the sample after the event.
    task automatic wait_fall(input int limit, output bit ok);
        logic prev;
        ok = 1'b0;
        prev = CLK_OUT;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (prev && !CLK_OUT) begin
                ok = 1'b1;
                break;
            end
            prev = CLK_OUT;
        end
    endtask

    task automatic wait_tick(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (TICK) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int act_at;
        int rise_at;
        act_at  = -1;
        rise_at = -1;
        RES = 1'b0;
        EN  = 1'b1;
        DIV = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: clk/tick/act=%b expected 000", i, {CLK_OUT, TICK, ACTIVE});
            end
        end
        RES = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {m_clk, m_tick, m_run}) begin
                errors++;
                $display("FAIL reset_start cyc %0d: got %b expected %b", k, {CLK_OUT, TICK, ACTIVE}, {m_clk, m_tick, m_run});
            end
            if (ACTIVE === 1'b1 && act_at < 0) act_at = k;
            if (CLK_OUT === 1'b1 && rise_at < 0) rise_at = k;
        end
        checks++;
        if (act_at != 1) begin
            errors++;
            $display("FAIL reset_active_rise: at cycle %0d expected 1", act_at);
        end
        checks++;
        if (rise_at != 7 || rise_at - act_at != 6) begin
            errors++;
            $display("FAIL reset_first_rise: at cycle %0d (active %0d) expected 7 (latency 6)", rise_at, act_at);
        end
    endtask

    task automatic test_default_period;
        bit ok;
        int n;
        int hi;
        DIV = 8'd3;
        wait_fall(40, ok);
        wait_tick(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL default_tick_timeout: no TICK within 20 cycles, expected one");
        end
        n  = 0;
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n++;
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {m_clk, m_tick, m_run}) begin
                errors++;
                $display("FAIL default_model cyc %0d: got %b expected %b", i, {CLK_OUT, TICK, ACTIVE}, {m_clk, m_tick, m_run});
            end
            if (TICK) break;
            if (CLK_OUT) hi++;
        end
        checks++;
        if (n != 8 || hi != 4) begin
            errors++;
            $display("FAIL default_period: period %0d high %0d expected 8 and 4", n, hi);
        end
    endtask

    task automatic test_boundary_update;
        bit   ok;
        logic exp_clk;
        wait_fall(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL update_fall_timeout: no fall within 20 cycles, expected one");
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge CLK);
            exp_clk = (i < 4) ? 1'b0 : (i < 8) ? 1'b1 : (((i - 8) % 4) >= 2);
            checks++;
            if (CLK_OUT !== exp_clk || {TICK, ACTIVE} !== {m_tick, m_run} || CLK_OUT !== m_clk) begin
                errors++;
                $display("FAIL update_pattern cyc %0d: clk/tick/act=%b expected clk %b model %b", i, {CLK_OUT, TICK, ACTIVE}, exp_clk, {m_clk, m_tick, m_run});
            end
            if (i == 1) DIV = 8'd1;
        end
    endtask

    task automatic test_graceful_stop;
        bit   ok;
        logic exp_clk;
        logic exp_act;
        DIV = 8'd3;
        wait_fall(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stop_fall_timeout: no fall within 20 cycles, expected one");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge CLK);
            exp_clk = (i >= 4 && i < 8);
            exp_act = (i < 8);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {exp_clk, (i == 4) ? 1'b1 : 1'b0, exp_act}) begin
                errors++;
                $display("FAIL stop_pattern cyc %0d: clk/tick/act=%b expected %b", i, {CLK_OUT, TICK, ACTIVE}, {exp_clk, (i == 4) ? 1'b1 : 1'b0, exp_act});
            end
            if (i == 1) EN = 1'b0;
        end
    endtask

    task automatic test_extremes;
        int t_prev;
        int t_last;
        DIV = 8'd0;
        EN  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {i[0], i[0], 1'b1}) begin
                errors++;
                $display("FAIL d0_pattern cyc %0d: clk/tick/act=%b expected %b", i, {CLK_OUT, TICK, ACTIVE}, {i[0], i[0], 1'b1});
            end
        end
        DIV    = 8'd255;
        t_prev = -1;
        t_last = -1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {m_clk, m_tick, m_run}) begin
                errors++;
                $display("FAIL d255_model cyc %0d: got %b expected %b", i, {CLK_OUT, TICK, ACTIVE}, {m_clk, m_tick, m_run});
            end
            if (TICK === 1'b1) begin
                t_prev = t_last;
                t_last = i;
            end
        end
        checks++;
        if (t_prev < 0 || t_last - t_prev != 512) begin
            errors++;
            $display("FAIL d255_period: tick spacing %0d (ticks at %0d,%0d) expected 512", t_last - t_prev, t_prev, t_last);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        int act_at;
        int rise_at;
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL areset_tick_timeout: no TICK within 600 cycles, expected one");
        end
        repeat (3) @(negedge CLK);
        #2 RES = 1'b0;
        #1;
        checks++;
        if ({CLK_OUT, TICK, ACTIVE} !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate: clk/tick/act=%b expected 000", {CLK_OUT, TICK, ACTIVE});
        end
        DIV = 8'd4;
        @(negedge CLK);
        checks++;
        if ({CLK_OUT, TICK, ACTIVE} !== 3'b000) begin
            errors++;
            $display("FAIL areset_held: clk/tick/act=%b expected 000", {CLK_OUT, TICK, ACTIVE});
        end
        RES     = 1'b1;
        act_at  = -1;
        rise_at = -1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {m_clk, m_tick, m_run}) begin
                errors++;
                $display("FAIL areset_restart cyc %0d: got %b expected %b", k, {CLK_OUT, TICK, ACTIVE}, {m_clk, m_tick, m_run});
            end
            if (ACTIVE === 1'b1 && act_at < 0) act_at = k;
            if (CLK_OUT === 1'b1 && rise_at < 0) rise_at = k;
        end
        checks++;
        if (act_at != 1 || rise_at - act_at != 5) begin
            errors++;
            $display("FAIL areset_new_div: active at %0d rise at %0d expected 1 and latency 5", act_at, rise_at);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            checks++;
            if ({CLK_OUT, TICK, ACTIVE} !== {m_clk, m_tick, m_run}) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %b expected %b", i, {CLK_OUT, TICK, ACTIVE}, {m_clk, m_tick, m_run});
            end
            if ($urandom_range(0, 7) == 0) DIV = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) EN = ~EN;
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_boundary_update();
        test_graceful_stop();
        test_extremes();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
